pc_register: RTL
================

Name: pc_register

Overview:
- 16-bit program counter that sources the CPU address bus during instruction fetch. It is the upstream neighbour of the address registers and the memory address path.
- Loadable byte-wise from the 8-bit shared data bus, readable back onto it, and auto-incrementing under control-unit command.
- A low-byte shadow makes jumps atomic: the address bus never shows a half-updated target.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (8): width of the shared data bus and of each PC byte.
- ADDR_WIDTH, 2*DATA_WIDTH (16): PC width; must equal 2*DATA_WIDTH.
- RESET_VECTOR, 0: PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- CS  input  1  chip select; gates every WE_*/OE_* strobe below.
- WE_L  input  1  capture data into the low-byte shadow.
- WE_H  input  1  capture data as the high byte and commit the jump.
- OE_L  input  1  drive PC[DATA_WIDTH-1:0] onto data.
- OE_H  input  1  drive PC[ADDR_WIDTH-1:DATA_WIDTH] onto data.
- OE_A  input  1  drive PC onto address; not gated by CS.
- INC  input  1  increment PC by 1.
- data  inout  DATA_WIDTH  shared data bus, tristate.
- address  output  ADDR_WIDTH  address bus, tristate; Z when OE_A=0.
- pc_out  output  ADDR_WIDTH  PC, always visible, for control-unit and debug use.
- wrap  output  1  one-cycle pulse on FFFF->0000 increment.

Behaviour:
- State: pc[ADDR_WIDTH], shadow_l[DATA_WIDTH], pending (1 bit), wrap (1 bit).
- Reset (sync, highest priority): pc=RESET_VECTOR, shadow_l=0, pending=0, wrap=0. Reset mid-load discards the shadow.
- Effective strobes: wl=CS&WE_L, wh=CS&WE_H, rl=CS&OE_L, rh=CS&OE_H.
- wl only: shadow_l<=data, pending<=1; pc unchanged, so address keeps showing the old PC.
- wh: pc<={data, pending ? shadow_l : pc[low]}, pending<=0. A high-only write keeps the current low byte.
- wl & wh in the same cycle: pc<={data,data}, pending<=0.
- INC with no wh: pc<=pc+1, modulo 2^ADDR_WIDTH.
- INC with wh: load wins and the increment is dropped.
- INC with wl only: increment and shadow capture both apply; pending is set.
- wrap<=1 for exactly the cycle following an increment from all-ones to 0; otherwise 0.
- Read-back, combinational: data=pc[low] if rl, else pc[high] if rh, else Z. rl has priority over rh.
- Read-back returns committed pc, never shadow_l.
- Write suppresses drive: if wl|wh is asserted, data is not driven regardless of rl/rh.
- address = OE_A ? pc : Z, combinational. Values reflect pc after the last edge (0-cycle latency).
- Load latency: a new PC is visible on pc_out/address one edge after wh.
- pending holds indefinitely until wh or reset; a second wl overwrites shadow_l.

Decomposition:
- Shared package / defines: `DATA_WIDTH, RESET_VECTOR default, and the width relation ADDR_WIDTH=2*DATA_WIDTH.
- One natural sub-module, pc_incrementer: combinational ADDR_WIDTH adder producing pc+1 and carry-out; carry-out drives wrap.
- Tristate drive reuses the existing tri_state_buffer for address. data drive is local.

Test Plan:
- Reset, then OE_A=1 -> address=0000, pc_out=0000, wrap=0, data=Z.
- CS, WE_L, data=34, one edge -> address still 0000. Then WE_H, data=12, one edge -> pc_out=1234, pending=0.
- pc=FFFE, INC for 2 edges -> FFFF, then 0000; wrap=1 for exactly one cycle after the second edge.
- pc=00FF, WE_H data=AB with INC in the same cycle -> pc=ABFF, no increment, no wrap.
- pc=1234, CS+OE_L -> data=34; CS+OE_L+OE_H -> data=34; CS+OE_H -> data=12; CS+OE_L+WE_L -> data not driven; OE_A=0 -> address=Z.
- WE_L data=77, then reset, then WE_H data=40 -> pc=4000 (shadow discarded); OE_L read -> 00.

Source files
------------

// File: rtl/pc_register_pkg.sv
// Shared widths and reset value for the program counter block.
// Every pc_register file imports this package.
package pc_register_pkg;
  localparam int DATA_WIDTH   = 8;
  localparam int ADDR_WIDTH   = 2 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0;
endpackage

// File: rtl/pc_register_if.sv
// Control strobes and status between the control unit (master) and the PC (slave).
// The data and address buses stay plain tristate ports on the PC.
interface pc_register_if;
  import pc_register_pkg::*;

  logic                  CS;
  logic                  WE_L;
  logic                  WE_H;
  logic                  OE_L;
  logic                  OE_H;
  logic                  OE_A;
  logic                  INC;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic                  wrap;

  modport master (output CS, WE_L, WE_H, OE_L, OE_H, OE_A, INC,
                  input  pc_out, wrap);
  modport slave  (input  CS, WE_L, WE_H, OE_L, OE_H, OE_A, INC,
                  output pc_out, wrap);
endinterface

// File: rtl/pc_register_incrementer.sv
// Combinational +1 adder for the program counter; the carry-out flags an all-ones wrap.
module pc_incrementer #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_value,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);
  assign {o_carry, o_sum} = {1'b0, i_value} + {{WIDTH{1'b0}}, 1'b1};
endmodule

// File: rtl/tri_state_buffer.sv
// Generic tristate driver: passes i_data when i_en, otherwise floats the output.
module tri_state_buffer #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  output wire  [WIDTH-1:0] o_data
);
  assign o_data = i_en ? i_data : {WIDTH{1'bz}};
endmodule

// File: rtl/pc_register.sv
// 16-bit program counter with byte-wise load through a low-byte shadow,
// read-back onto the shared data bus, auto-increment and wrap pulse.
module pc_register
  import pc_register_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  pc_register_if.slave          bus,
  inout  wire  [DATA_WIDTH-1:0] data,
  output wire  [ADDR_WIDTH-1:0] address
);
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_shadow_l;
  logic                  r_pending;
  logic                  r_wrap;

  logic                  w_wl;
  logic                  w_wh;
  logic                  w_rl;
  logic                  w_rh;
  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic                  w_carry;
  logic [DATA_WIDTH-1:0] w_low_src;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_rd_en;

  assign w_wl = bus.CS & bus.WE_L;
  assign w_wh = bus.CS & bus.WE_H;
  assign w_rl = bus.CS & bus.OE_L;
  assign w_rh = bus.CS & bus.OE_H;

  pc_incrementer #(.WIDTH(ADDR_WIDTH)) u_inc (
    .i_value (r_pc),
    .o_sum   (w_pc_inc),
    .o_carry (w_carry)
  );

  // A same-cycle low write bypasses the shadow; otherwise a high-only write keeps the old low byte.
  always_comb begin
    w_low_src = r_pc[DATA_WIDTH-1:0];
    if (w_wl)
      w_low_src = data;
    else if (r_pending)
      w_low_src = r_shadow_l;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_VECTOR;
      r_shadow_l <= '0;
      r_pending  <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      if (w_wh) begin
        r_pc      <= {data, w_low_src};
        r_pending <= 1'b0;
      end else begin
        if (bus.INC)
          r_pc <= w_pc_inc;
        if (w_wl) begin
          r_shadow_l <= data;
          r_pending  <= 1'b1;
        end
      end
      r_wrap <= bus.INC & ~w_wh & w_carry;
    end
  end

  // Any write strobe turns the data bus into an input, so read-back is suppressed.
  assign w_rd_en   = (w_rl | w_rh) & ~(w_wl | w_wh);
  assign w_rd_data = w_rl ? r_pc[DATA_WIDTH-1:0] : r_pc[ADDR_WIDTH-1:DATA_WIDTH];
  assign data      = w_rd_en ? w_rd_data : {DATA_WIDTH{1'bz}};

  tri_state_buffer #(.WIDTH(ADDR_WIDTH)) u_addr_buf (
    .i_data (r_pc),
    .i_en   (bus.OE_A),
    .o_data (address)
  );

  assign bus.pc_out = r_pc;
  assign bus.wrap   = r_wrap;
endmodule
